// File: rtl/dibit_word_receiver.sv
// Dibit word receiver: samples 2-bit symbols qualified by the sender's drive-enable,
// packs DIBITS of them MSB-first into a word, and hands it off on a valid/ready register.
module dibit_word_receiver #(
    parameter int DIBITS  = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [1:0]            d,
    input  logic                  d_en,
    input  logic                  sof,
    output logic [2*DIBITS-1:0]   q,
    output logic                  q_valid,
    input  logic                  q_ready,
    output logic                  err,
    output logic                  ovr
);

    localparam int W  = 2 * DIBITS;
    localparam int CW = $clog2(DIBITS + 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next, cnt_inc;
    logic [7:0]      gap_reg, gap_next;
    logic [8:0]      gap_inc;
    // Only DIBITS-1 dibits ever need storing: the last one is merged straight from d.
    logic [W-3:0]    shift_reg, shift_next;
    logic [W-1:0]    word;
    logic            complete, abort;

    logic [W-1:0]    q_reg, q_next;
    logic            q_valid_reg, q_valid_next;
    logic            err_reg, err_next;
    logic            ovr_reg, ovr_next;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            gap_reg     <= '0;
            shift_reg   <= '0;
            q_reg       <= '0;
            q_valid_reg <= 1'b0;
            err_reg     <= 1'b0;
            ovr_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            gap_reg     <= gap_next;
            shift_reg   <= shift_next;
            q_reg       <= q_next;
            q_valid_reg <= q_valid_next;
            err_reg     <= err_next;
            ovr_reg     <= ovr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        gap_next   = gap_reg;
        shift_next = shift_reg;
        word       = {shift_reg, d};
        cnt_inc    = cnt_reg + 1'b1;
        gap_inc    = {1'b0, gap_reg} + 9'd1;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (d_en && sof) begin
                    shift_next = (W-2)'(d);
                    cnt_next   = CW'(1);
                    gap_next   = '0;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (d_en) begin
                    gap_next = '0;
                    if (sof) begin
                        abort      = 1'b1;
                        shift_next = (W-2)'(d);
                        cnt_next   = CW'(1);
                    end else if (cnt_inc == CW'(DIBITS)) begin
                        complete   = 1'b1;
                        shift_next = '0;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        shift_next = word[W-3:0];
                        cnt_next   = cnt_inc;
                    end
                end else if (gap_inc == 9'(TIMEOUT)) begin
                    abort      = 1'b1;
                    shift_next = '0;
                    cnt_next   = '0;
                    gap_next   = '0;
                    state_next = IDLE;
                end else begin
                    gap_next = gap_inc[7:0];
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The output slot is free when empty or being drained at this very edge.
    always_comb begin
        q_next       = q_reg;
        q_valid_next = q_valid_reg;
        err_next     = abort;
        ovr_next     = 1'b0;
        if (q_valid_reg && q_ready)
            q_valid_next = 1'b0;
        if (complete) begin
            if (!q_valid_reg || q_ready) begin
                q_next       = word;
                q_valid_next = 1'b1;
            end else begin
                ovr_next = 1'b1;
            end
        end
    end

    assign q       = q_reg;
    assign q_valid = q_valid_reg;
    assign err     = err_reg;
    assign ovr     = ovr_reg;

endmodule

// File: tb/tb_dibit_word_receiver.sv
// Bench for dibit_word_receiver: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the receive rules.
module tb_dibit_word_receiver;

    localparam int DIBITS  = 4;
    localparam int TIMEOUT = 8;
    localparam int W       = 2 * DIBITS;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic [1:0]   d = 2'b00;
    logic         d_en = 1'b0;
    logic         sof = 1'b0;
    logic [W-1:0] q;
    logic         q_valid;
    logic         q_ready = 1'b0;
    logic         err;
    logic         ovr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: dibits received so far in the current word, idle run length, held output.
    int           partial[$];
    int           idle_cnt = 0;
    logic [W-1:0] m_q = '0;
    bit           m_valid = 0, m_err = 0, m_ovr = 0, m_rst = 0;

    dibit_word_receiver #(.DIBITS(DIBITS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .clr(clr), .d(d), .d_en(d_en), .sof(sof),
        .q(q), .q_valid(q_valid), .q_ready(q_ready), .err(err), .ovr(ovr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [1:0] md, input bit men, input bit msof, input bit mrdy, input bit mclr);
        bit           free;
        logic [W-1:0] w;
        m_err = 0;
        m_ovr = 0;
        m_rst = mclr;
        if (mclr) begin
            partial.delete();
            idle_cnt = 0;
            m_q      = '0;
            m_valid  = 0;
            return;
        end
        free = !m_valid || mrdy;
        if (m_valid && mrdy) m_valid = 0;
        if (men) begin
            if (msof) begin
                if (partial.size() > 0) m_err = 1;
                partial.delete();
                partial.push_back(int'(md));
                idle_cnt = 0;
            end else if (partial.size() > 0) begin
                partial.push_back(int'(md));
                idle_cnt = 0;
            end
        end else if (partial.size() > 0) begin
            idle_cnt++;
            if (idle_cnt == TIMEOUT) begin
                m_err = 1;
                partial.delete();
                idle_cnt = 0;
            end
        end
        if (partial.size() == DIBITS) begin
            w = '0;
            foreach (partial[i]) w = w * 4 + W'(partial[i]);
            partial.delete();
            if (free) begin
                m_q     = w;
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end
    endtask

    task automatic cycle(input logic [1:0] cd, input bit cen, input bit csof, input bit crdy, input bit cclr);
        d       = cd;
        d_en    = cen;
        sof     = csof;
        q_ready = crdy;
        clr     = cclr;
        @(posedge clk);
        model(cd, cen, csof, crdy, cclr);
        #1;
        check("q_valid", 32'(q_valid), 32'(m_valid));
        check("err", 32'(err), 32'(m_err));
        check("ovr", 32'(ovr), 32'(m_ovr));
        if (m_valid || m_rst) check("q", 32'(q), 32'(m_q));
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) cycle(2'($urandom), 1'b0, 1'($urandom), rdy, 1'b0);
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gap, input bit rdy_body, input bit rdy_last);
        for (int i = DIBITS - 1; i >= 0; i--) begin
            if (i < DIBITS - 1) idle(gap, rdy_body);
            cycle(w[2*i +: 2], 1'b1, i == DIBITS - 1, (i == 0) ? rdy_last : rdy_body, 1'b0);
        end
        $display("word %h sent: q=%h q_valid=%b err=%b ovr=%b", w, q, q_valid, err, ovr);
    endtask

    initial begin
        // Reset with random bus activity
        repeat (2) cycle(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        check("rst_q", 32'(q), 32'h0);
        check("rst_valid", 32'(q_valid), 32'h0);
        idle(2, 1'b0);

        // Basic word held until ready
        send_word(8'h9C, 0, 1'b0, 1'b0);
        check("basic_q", 32'(q), 32'h9C);
        check("basic_valid", 32'(q_valid), 32'h1);
        idle(3, 1'b0);
        cycle(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("basic_drain", 32'(q_valid), 32'h0);

        // Maximal legal gaps, then a timeout, then a clean word
        send_word(8'hA5, TIMEOUT - 1, 1'b0, 1'b0);
        check("gap_q", 32'(q), 32'hA5);
        check("gap_err", 32'(err), 32'h0);
        cycle(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(TIMEOUT - 1, 1'b0);
        check("pre_timeout_err", 32'(err), 32'h0);
        cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("timeout_err", 32'(err), 32'h1);
        check("timeout_valid", 32'(q_valid), 32'h0);
        idle(1, 1'b0);
        send_word(8'h3C, 0, 1'b0, 1'b0);
        check("after_timeout_q", 32'(q), 32'h3C);
        cycle(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

        // Restart mid-word
        cycle(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        check("restart_err", 32'(err), 32'h1);
        cycle(2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        check("restart_q", 32'(q), 32'h6C);
        cycle(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

        // Overrun, then the same with ready at the completion edge
        send_word(8'h11, 0, 1'b0, 1'b0);
        send_word(8'h22, 0, 1'b0, 1'b0);
        check("ovr_pulse", 32'(ovr), 32'h1);
        check("ovr_q", 32'(q), 32'h11);
        cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovr_one_cycle", 32'(ovr), 32'h0);
        cycle(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(8'h11, 0, 1'b0, 1'b0);
        send_word(8'h22, 0, 1'b0, 1'b1);
        check("swap_ovr", 32'(ovr), 32'h0);
        check("swap_q", 32'(q), 32'h22);
        check("swap_valid", 32'(q_valid), 32'h1);
        cycle(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

        // Streaming with no bubbles, then reset mid-word
        send_word(8'hF0, 0, 1'b1, 1'b1);
        check("stream0", 32'(q), 32'hF0);
        send_word(8'h0F, 0, 1'b1, 1'b1);
        check("stream1", 32'(q), 32'h0F);
        send_word(8'h5A, 0, 1'b1, 1'b1);
        check("stream2", 32'(q), 32'h5A);
        check("stream2_valid", 32'(q_valid), 32'h1);
        cycle(2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
        check("midreset_valid", 32'(q_valid), 32'h0);
        cycle(2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        check("midreset_quiet", 32'(q_valid), 32'h0);
        send_word(8'hC3, 0, 1'b1, 1'b1);
        check("midreset_next", 32'(q), 32'hC3);

        // Random traffic: alternating dense and sparse phases to hit timeouts and overruns
        for (int i = 0; i < 4000; i++) begin
            bit en;
            if ((i % 500) < 250) en = ($urandom_range(0, 9) < 8);
            else                 en = ($urandom_range(0, 9) < 2);
            cycle(2'($urandom), en, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 299) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
